sseg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It drives the 3-bit digit select into the 8:1 segment-pattern mux directly downstream, and produces the matching active-low anode enables and decimal point. Each digit gets a fixed time slot with a leading blanking interval, which suppresses ghosting while the mux output settles. Per-digit masking and a scan enable are included.

---
 rtl/sseg_pkg.sv | 27 ++
 rtl/sseg_slot_counter.sv | 42 ++++
 rtl/sseg_scan_ctrl.sv | 111 +++++++++++
 tb/tb_sseg_scan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Anode enables are active-low, so "all off" is all ones.
package sseg_pkg;

    typedef logic [2:0] digit_idx_t;
    typedef logic [7:0] anode_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam anode_t ANODES_OFF = 8'hFF;

    // One-hot-low anode pattern for a digit, or all off when the digit is dark
    function automatic anode_t anode_decode(input digit_idx_t idx, input logic lit);
        anode_t a;
        a = ANODES_OFF;
        if (lit) begin
            a[idx] = 1'b0;
        end else begin
            a = ANODES_OFF;
        end
        return a;
    endfunction

endpackage

// File: rtl/sseg_slot_counter.sv
// Modulo-CLK_DIV slot counter with hold enable and synchronous reset.
// Flags the last blanking cycle and the last cycle of the slot.
module sseg_slot_counter #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             blank_done,
    output logic             slot_done
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Slot position register: wraps at CLK_DIV-1, frozen while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt        = cnt_r;
    assign blank_done = (cnt_r == BLANK_LAST);
    assign slot_done  = (cnt_r == CNT_LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: BLANK/SHOW slot FSM with
// outputs decoded from next-state values so they line up with the slot.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] digit_mask,
    input  logic [7:0] dp_in,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] slot_cnt_unused_s;
    logic             blank_done_s;
    logic             slot_done_s;

    scan_state_t state_r, state_s;
    digit_idx_t  sel_r, sel_s;
    anode_t      an_r, an_s;
    logic        dp_r, dp_s;
    logic        frame_tick_r, frame_tick_s;

    sseg_slot_counter #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_slot_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cnt        (slot_cnt_unused_s),
        .blank_done (blank_done_s),
        .slot_done  (slot_done_s)
    );

    // Next-state, next-digit and output decode for the cycle after this edge
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        an_s         = ANODES_OFF;
        dp_s         = 1'b1;
        frame_tick_s = 1'b0;
        if (en) begin
            case (state_r)
                BLANK: begin
                    if (blank_done_s) begin
                        state_s = SHOW;
                    end else begin
                        state_s = BLANK;
                    end
                end
                SHOW: begin
                    if (slot_done_s) begin
                        state_s      = BLANK;
                        sel_s        = sel_r + 3'd1;
                        frame_tick_s = (sel_r == 3'd7);
                    end else begin
                        state_s = SHOW;
                    end
                end
                default: begin
                    state_s = BLANK;
                end
            endcase
            // Decoding from sel_s/state_s makes the first SHOW cycle already lit
            if (state_s == SHOW) begin
                an_s = anode_decode(sel_s, digit_mask[sel_s]);
                dp_s = ~(digit_mask[sel_s] & dp_in[sel_s]);
            end else begin
                an_s = ANODES_OFF;
                dp_s = 1'b1;
            end
        end else begin
            an_s         = ANODES_OFF;
            dp_s         = 1'b1;
            frame_tick_s = 1'b0;
        end
    end

    // State and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= BLANK;
            sel_r        <= 3'd0;
            an_r         <= ANODES_OFF;
            dp_r         <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            an_r         <= an_s;
            dp_r         <= dp_s;
            frame_tick_r <= frame_tick_s;
        end
    end

    assign sel        = sel_r;
    assign an         = an_r;
    assign dp         = dp_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: a cycle model feeds per-DUT
// scoreboard queues, and each scenario task adds directed checks.
module tb_sseg_scan_ctrl;

    typedef struct {
        int         cnt;
        int         sel;
        logic [7:0] an;
        logic       dp;
        logic       ft;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] digit_mask;
    logic [7:0] dp_in;
    logic [2:0] sel_a, sel_b;
    logic [7:0] an_a, an_b;
    logic       dp_a, dp_b, ft_a, ft_b;

    int tests  = 0;
    int failed = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ma = '{0, 0, 8'hFF, 1'b1, 1'b0};
    exp_t mb = '{0, 0, 8'hFF, 1'b1, 1'b0};

    sseg_scan_ctrl #(.CLK_DIV(10), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask), .dp_in(dp_in),
        .sel(sel_a), .an(an_a), .dp(dp_a), .frame_tick(ft_a)
    );

    sseg_scan_ctrl #(.CLK_DIV(2), .BLANK_CYCLES(1)) dut_small (
        .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask), .dp_in(dp_in),
        .sel(sel_b), .an(an_b), .dp(dp_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: slot position counting, outputs describe the cycle after the edge
    function automatic exp_t model_step(input int div, input int blank, input exp_t cur,
                                        input logic rst, input logic ena,
                                        input logic [7:0] mask, input logic [7:0] dpi);
        exp_t n;
        logic wrap;
        n    = cur;
        n.an = 8'hFF;
        n.dp = 1'b1;
        n.ft = 1'b0;
        if (rst) begin
            n.cnt = 0;
            n.sel = 0;
        end else if (ena) begin
            wrap  = (cur.cnt == div - 1);
            n.cnt = wrap ? 0 : cur.cnt + 1;
            n.sel = wrap ? (cur.sel + 1) % 8 : cur.sel;
            n.ft  = wrap && (n.sel == 0);
            if (n.cnt >= blank && mask[n.sel]) begin
                n.an = 8'hFF ^ (8'h01 << n.sel);
                n.dp = ~dpi[n.sel];
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= model_step(10, 2, ma, reset, en, digit_mask, dp_in);
        mb <= model_step(2, 1, mb, reset, en, digit_mask, dp_in);
        qa.push_back(model_step(10, 2, ma, reset, en, digit_mask, dp_in));
        qb.push_back(model_step(2, 1, mb, reset, en, digit_mask, dp_in));
    end

    // Wait to the falling edge and pop the expectations for the cycle now visible
    task automatic advance(output exp_t ea, output exp_t eb);
        @(negedge clk);
        if (qa.size() > 0) ea = qa.pop_front();
        else ea = '{-1, -1, 8'hxx, 1'bx, 1'bx};
        if (qb.size() > 0) eb = qb.pop_front();
        else eb = '{-1, -1, 8'hxx, 1'bx, 1'bx};
    endtask

    task automatic test_reset();
        exp_t ea, eb;
        logic [7:0] xan;
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            advance(ea, eb);
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {3'd0, 8'hFF, 1'b1, 1'b0}) begin
                failed++;
                $display("FAIL reset_hold c%0d: got sel=%0d an=%h dp=%b ft=%b, want sel=0 an=ff dp=1 ft=0", i, sel_a, an_a, dp_a, ft_a);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            advance(ea, eb);
            xan = (k < 2 || k == 10) ? 8'hFF : 8'hFE;
            tests++;
            if ({sel_a, an_a, ft_a} !== {((k == 10) ? 3'd1 : 3'd0), xan, 1'b0}) begin
                failed++;
                $display("FAIL reset_release k%0d: got sel=%0d an=%h ft=%b, want an=%h", k, sel_a, an_a, ft_a, xan);
            end
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {ea.sel[2:0], ea.an, ea.dp, ea.ft}) begin
                failed++;
                $display("FAIL reset_model k%0d: got an=%h sel=%0d, want an=%h sel=%0d", k, an_a, sel_a, ea.an, ea.sel);
            end
        end
    endtask

    task automatic test_full_frame();
        exp_t ea, eb;
        logic [7:0] xan;
        int xsel;
        int low_cnt[8];
        foreach (low_cnt[i]) low_cnt[i] = 0;
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'h00;
        advance(ea, eb);
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            advance(ea, eb);
            xsel = (k / 10) % 8;
            xan  = (k % 10 >= 2) ? (8'hFF ^ (8'h01 << xsel)) : 8'hFF;
            if (an_a != 8'hFF) low_cnt[sel_a]++;
            tests++;
            if ({sel_a, an_a, ft_a} !== {xsel[2:0], xan, (k == 80)}) begin
                failed++;
                $display("FAIL full_frame k%0d: got sel=%0d an=%h ft=%b, want sel=%0d an=%h ft=%b", k, sel_a, an_a, ft_a, xsel, xan, (k == 80));
            end
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {ea.sel[2:0], ea.an, ea.dp, ea.ft}) begin
                failed++;
                $display("FAIL full_frame_model k%0d: got an=%h ft=%b, want an=%h ft=%b", k, an_a, ft_a, ea.an, ea.ft);
            end
        end
        for (int d = 0; d < 8; d++) begin
            tests++;
            if (low_cnt[d] != 8) begin
                failed++;
                $display("FAIL frame_low_count d%0d: got %0d cycles, want 8", d, low_cnt[d]);
            end
        end
    endtask

    task automatic test_masking();
        exp_t ea, eb;
        logic [7:0] xan;
        logic xdp;
        int xsel;
        reset = 1'b1; en = 1'b1; digit_mask = 8'h05; dp_in = 8'h04;
        advance(ea, eb);
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            advance(ea, eb);
            xsel = (k / 10) % 8;
            xan  = ((k % 10 >= 2) && (xsel == 0 || xsel == 2)) ? (8'hFF ^ (8'h01 << xsel)) : 8'hFF;
            xdp  = !((k % 10 >= 2) && xsel == 2);
            tests++;
            if ({sel_a, an_a, dp_a} !== {xsel[2:0], xan, xdp}) begin
                failed++;
                $display("FAIL masking k%0d: got sel=%0d an=%h dp=%b, want sel=%0d an=%h dp=%b", k, sel_a, an_a, dp_a, xsel, xan, xdp);
            end
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {ea.sel[2:0], ea.an, ea.dp, ea.ft}) begin
                failed++;
                $display("FAIL masking_model k%0d: got an=%h dp=%b, want an=%h dp=%b", k, an_a, dp_a, ea.an, ea.dp);
            end
        end
    endtask

    task automatic test_scan_enable();
        exp_t ea, eb;
        int shown;
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'hFF;
        advance(ea, eb);
        reset = 1'b0;
        for (int k = 1; k <= 34; k++) advance(ea, eb);
        tests++;
        if ({sel_a, an_a} !== {3'd3, 8'hF7}) begin
            failed++;
            $display("FAIL enable_setup: got sel=%0d an=%h, want sel=3 an=f7", sel_a, an_a);
        end
        // scan frozen from the cycle that would have been cnt=5 of digit 3
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance(ea, eb);
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {3'd3, 8'hFF, 1'b1, 1'b0}) begin
                failed++;
                $display("FAIL enable_frozen c%0d: got sel=%0d an=%h dp=%b ft=%b, want sel=3 an=ff dp=1 ft=0", i, sel_a, an_a, dp_a, ft_a);
            end
        end
        en = 1'b1;
        shown = 0;
        for (int i = 0; i < 12 && sel_a == 3'd3; i++) begin
            advance(ea, eb);
            if (sel_a == 3'd3 && an_a == 8'hF7 && dp_a == 1'b0) shown++;
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {ea.sel[2:0], ea.an, ea.dp, ea.ft}) begin
                failed++;
                $display("FAIL enable_model c%0d: got sel=%0d an=%h, want sel=%0d an=%h", i, sel_a, an_a, ea.sel, ea.an);
            end
        end
        tests++;
        if (shown != 5 || {sel_a, an_a} !== {3'd4, 8'hFF}) begin
            failed++;
            $display("FAIL enable_resume: got %0d lit cycles then sel=%0d an=%h, want 5 then sel=4 an=ff", shown, sel_a, an_a);
        end
    endtask

    task automatic test_reset_mid_show();
        exp_t ea, eb;
        logic [7:0] xan;
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'h00;
        advance(ea, eb);
        reset = 1'b0;
        for (int k = 1; k <= 67; k++) advance(ea, eb);
        tests++;
        if ({sel_a, an_a} !== {3'd6, 8'hBF}) begin
            failed++;
            $display("FAIL midshow_setup: got sel=%0d an=%h, want sel=6 an=bf", sel_a, an_a);
        end
        reset = 1'b1; en = 1'b0;
        advance(ea, eb);
        tests++;
        if ({sel_a, an_a, dp_a, ft_a} !== {3'd0, 8'hFF, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL midshow_reset: got sel=%0d an=%h dp=%b ft=%b, want sel=0 an=ff dp=1 ft=0", sel_a, an_a, dp_a, ft_a);
        end
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            advance(ea, eb);
            xan = (k % 10 >= 2) ? (8'hFF ^ (8'h01 << (k / 10))) : 8'hFF;
            tests++;
            if ({an_a, ft_a} !== {xan, 1'b0}) begin
                failed++;
                $display("FAIL midshow_after k%0d: got an=%h ft=%b, want an=%h ft=0", k, an_a, ft_a, xan);
            end
        end
    endtask

    task automatic test_small_params();
        exp_t ea, eb;
        logic [7:0] xan;
        int xsel;
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'h00;
        advance(ea, eb);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            advance(ea, eb);
            xsel = (k / 2) % 8;
            xan  = (k % 2 == 1) ? (8'hFF ^ (8'h01 << xsel)) : 8'hFF;
            tests++;
            if ({sel_b, an_b, ft_b} !== {xsel[2:0], xan, (k == 16)}) begin
                failed++;
                $display("FAIL small_params k%0d: got sel=%0d an=%h ft=%b, want sel=%0d an=%h ft=%b", k, sel_b, an_b, ft_b, xsel, xan, (k == 16));
            end
        end
    endtask

    task automatic test_random();
        exp_t ea, eb;
        logic [2:0] prev_a, prev_b;
        prev_a = sel_a;
        prev_b = sel_b;
        for (int i = 0; i < 10000; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            digit_mask = 8'($urandom);
            dp_in      = 8'($urandom);
            advance(ea, eb);
            tests++;
            if ({sel_a, an_a, dp_a, ft_a} !== {ea.sel[2:0], ea.an, ea.dp, ea.ft}) begin
                failed++;
                $display("FAIL random_a c%0d: got sel=%0d an=%h dp=%b ft=%b, want sel=%0d an=%h dp=%b ft=%b", i, sel_a, an_a, dp_a, ft_a, ea.sel, ea.an, ea.dp, ea.ft);
            end
            tests++;
            if ({sel_b, an_b, dp_b, ft_b} !== {eb.sel[2:0], eb.an, eb.dp, eb.ft}) begin
                failed++;
                $display("FAIL random_b c%0d: got sel=%0d an=%h dp=%b ft=%b, want sel=%0d an=%h dp=%b ft=%b", i, sel_b, an_b, dp_b, ft_b, eb.sel, eb.an, eb.dp, eb.ft);
            end
            tests++;
            if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
                failed++;
                $display("FAIL one_hot_low c%0d: got an_a=%h an_b=%h, want at most one low bit", i, an_a, an_b);
            end
            tests++;
            if ((sel_a != prev_a && ea.cnt != 0) || (sel_b != prev_b && eb.cnt != 0)) begin
                failed++;
                $display("FAIL sel_boundary c%0d: got sel_a %0d->%0d sel_b %0d->%0d away from slot start", i, prev_a, sel_a, prev_b, sel_b);
            end
            prev_a = sel_a;
            prev_b = sel_b;
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; digit_mask = 8'hFF; dp_in = 8'h00;
        test_reset();
        test_full_frame();
        test_masking();
        test_scan_enable();
        test_reset_mid_show();
        test_small_params();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
